// File: rtl/flags_unit.sv
// Architectural condition-flag register {carry, negative, zero} with a LIFO
// save/restore stack for calls and returns, zero-cycle forwarding and sticky stack errors.
module flags_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         alu_carry,
    input  logic                         set_flags,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         clear_errors,
    output logic [2:0]                   flags,
    output logic [2:0]                   flags_fwd,
    output logic [$clog2(STACK_DEPTH):0] stack_count,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]       flags_reg, flags_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic [2:0]       stack_mem [STACK_DEPTH];
    logic [2:0]       cand_flags;
    logic [2:0]       top_entry;
    logic [PTR_W-1:0] push_idx, top_idx;
    logic             act, eff_push, eff_pop;
    logic             full, empty;
    logic             do_push, do_pop;

    assign cand_flags = {alu_carry, alu_result[DATA_WIDTH-1], ~|alu_result};

    assign act      = ~stall & ~flush;
    assign eff_push = act & push & ~pop;
    assign eff_pop  = act & pop & ~push;

    assign full  = (count_reg == CNT_W'(STACK_DEPTH));
    assign empty = (count_reg == '0);

    assign do_push = eff_push & ~full;
    assign do_pop  = eff_pop & ~empty;

    // Write slot is the current depth; the top entry sits one below it.
    assign push_idx  = count_reg[PTR_W-1:0];
    assign top_idx   = PTR_W'(count_reg - CNT_W'(1));
    assign top_entry = stack_mem[top_idx];

    always_comb begin
        flags_next     = flags_reg;
        count_next     = count_reg;
        overflow_next  = clear_errors ? 1'b0 : overflow_reg;
        underflow_next = clear_errors ? 1'b0 : underflow_reg;

        if (do_pop)
            flags_next = top_entry;
        else if (act & set_flags)
            flags_next = cand_flags;

        if (do_push)
            count_next = count_reg + CNT_W'(1);
        else if (do_pop)
            count_next = count_reg - CNT_W'(1);

        // A fresh error in the same cycle beats clear_errors.
        if (eff_push & full)
            overflow_next = 1'b1;
        if (eff_pop & empty)
            underflow_next = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg     <= 3'b000;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            flags_reg     <= flags_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Stack entries are not reset; stack_count alone defines which are valid.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (do_push && push_idx == PTR_W'(gi))
                stack_mem[gi] <= flags_reg;
        end
    end

    assign flags           = flags_reg;
    assign flags_fwd       = flags_next;
    assign stack_count     = count_reg;
    assign stack_overflow  = overflow_reg;
    assign stack_underflow = underflow_reg;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: directed vector table, stack corner sequences,
// asynchronous reset and randomized traffic against a queue-based reference model.
module tb_flags_unit;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] alu_result;
    logic          alu_carry, set_flags, push, pop, stall, flush, clear_errors;
    logic [2:0]    flags, flags_fwd;
    logic [3:0]    stack_count;
    logic          stack_overflow, stack_underflow;

    flags_unit #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .alu_result      (alu_result),
        .alu_carry       (alu_carry),
        .set_flags       (set_flags),
        .push            (push),
        .pop             (pop),
        .stall           (stall),
        .flush           (flush),
        .clear_errors    (clear_errors),
        .flags           (flags),
        .flags_fwd       (flags_fwd),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int passed = 0;
    int total  = 0;

    // Reference model: architectural flags, a queue as the stack, sticky errors.
    logic [2:0] m_flags;
    logic [2:0] m_stack[$];
    logic       m_ovf, m_unf;
    logic [2:0] last_fwd;

    typedef struct {
        logic        s;
        logic [31:0] r;
        logic        c, pu, po, st, fl, cl;
        logic [2:0]  e_fwd, e_flags;
        logic [3:0]  e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v === exp_v)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    endtask

    task automatic model_reset();
        m_flags = 3'b000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Entered at posedge+1; drives one cycle, checks forward value and post-edge state.
    task automatic step(input logic s, input logic [31:0] r, input logic c,
                        input logic pu, input logic po, input logic st,
                        input logic fl, input logic cl);
        logic       live, want_push, want_pop;
        logic [2:0] cand, nxt;
        set_flags = s; alu_result = r; alu_carry = c;
        push = pu; pop = po; stall = st; flush = fl; clear_errors = cl;

        cand      = {c, r[31], (r == 32'd0)};
        live      = !st && !fl;
        want_push = live && pu && !po;
        want_pop  = live && po && !pu;
        if (want_pop && m_stack.size() > 0) nxt = m_stack[m_stack.size()-1];
        else if (live && s)                 nxt = cand;
        else                                nxt = m_flags;

        #4;
        last_fwd = flags_fwd;
        check("flags_fwd", flags_fwd, nxt);
        @(posedge clock);

        if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (want_push) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else                        m_ovf = 1'b1;
        end
        if (want_pop) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else                    m_unf = 1'b1;
        end
        m_flags = nxt;

        #1;
        check("flags", flags, m_flags);
        check("stack_count", stack_count, m_stack.size());
        check("stack_overflow", stack_overflow, m_ovf);
        check("stack_underflow", stack_underflow, m_unf);
    endtask

    // Drops reset between edges with whatever inputs are live, checks the
    // asynchronous clear, holds reset across one edge, then releases at posedge+1.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_flags", flags, 0);
        check("rst_count", stack_count, 0);
        check("rst_ovf", stack_overflow, 0);
        check("rst_unf", stack_underflow, 0);
        set_flags = 0; alu_result = '0; alu_carry = 0; push = 0; pop = 0;
        stall = 0; flush = 0; clear_errors = 0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ALU inputs that produce a given (reachable) flag pattern.
    function automatic logic [31:0] res_for(input logic [2:0] p);
        if (p[0])      return 32'h0000_0000;
        else if (p[1]) return 32'h8000_0000;
        else           return 32'h0000_0001;
    endfunction

    logic [2:0] vals[8];
    logic [2:0] hist[8];

    initial begin
        reset_n = 1'b0;
        set_flags = 0; alu_result = '0; alu_carry = 0; push = 0; pop = 0;
        stall = 0; flush = 0; clear_errors = 0;
        model_reset();

        //           s  result          c  pu po st fl cl  fwd     flags   cnt ov un
        tbl[0]  = '{1, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 3'b101, 3'b101, 0, 0, 0};
        tbl[1]  = '{1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 0, 0, 0};
        tbl[2]  = '{1, 32'h0000_0001, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0};
        tbl[3]  = '{0, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 3'b010, 3'b010, 0, 0, 0};
        tbl[4]  = '{1, 32'h0000_0005, 1, 0, 0, 0, 0, 0, 3'b100, 3'b100, 0, 0, 0};
        tbl[5]  = '{1, 32'h8000_0000, 0, 0, 1, 0, 0, 0, 3'b010, 3'b010, 0, 0, 1};
        tbl[6]  = '{0, 32'h0000_0000, 0, 0, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 0};
        tbl[7]  = '{0, 32'h0000_0000, 0, 1, 0, 0, 0, 0, 3'b010, 3'b010, 1, 0, 0};
        tbl[8]  = '{1, 32'h0000_0000, 1, 1, 1, 1, 0, 0, 3'b010, 3'b010, 1, 0, 0};
        tbl[9]  = '{1, 32'h0000_0000, 1, 1, 0, 1, 0, 0, 3'b010, 3'b010, 1, 0, 0};
        tbl[10] = '{1, 32'h0000_0000, 1, 0, 0, 0, 1, 0, 3'b010, 3'b010, 1, 0, 0};
        tbl[11] = '{0, 32'h0000_0000, 0, 0, 1, 0, 1, 0, 3'b010, 3'b010, 1, 0, 0};
        tbl[12] = '{1, 32'h0000_0000, 0, 1, 1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0};
        tbl[13] = '{0, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 3'b010, 3'b010, 0, 0, 0};
        tbl[14] = '{0, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 3'b010, 3'b010, 0, 0, 1};
        tbl[15] = '{0, 32'h0000_0000, 0, 0, 0, 1, 0, 1, 3'b010, 3'b010, 0, 0, 0};
        tbl[16] = '{0, 32'h0000_0000, 0, 0, 1, 0, 0, 1, 3'b010, 3'b010, 0, 0, 1};

        vals = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b000, 3'b100, 3'b010};

        #2;
        check("init_flags", flags, 0);
        check("init_count", stack_count, 0);
        check("init_ovf", stack_overflow, 0);
        check("init_unf", stack_underflow, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].pu, tbl[i].po, tbl[i].st, tbl[i].fl, tbl[i].cl);
            $display("vec %0d: fwd=%b flags=%b cnt=%0d ovf=%b unf=%b",
                     i, last_fwd, flags, stack_count, stack_overflow, stack_underflow);
            check($sformatf("tbl%0d_fwd", i), last_fwd, tbl[i].e_fwd);
            check($sformatf("tbl%0d_flags", i), flags, tbl[i].e_flags);
            check($sformatf("tbl%0d_cnt", i), stack_count, tbl[i].e_cnt);
            check($sformatf("tbl%0d_ovf", i), stack_overflow, tbl[i].e_ovf);
            check($sformatf("tbl%0d_unf", i), stack_underflow, tbl[i].e_unf);
        end

        // Fill the stack: each push saves the old flags while loading a new pattern.
        do_reset();
        hist[0] = 3'b000;
        for (int i = 1; i < 8; i++) hist[i] = vals[i-1];
        for (int i = 0; i < 8; i++) begin
            step(1, res_for(vals[i]), vals[i][2], 1, 0, 0, 0, 0);
            $display("fill %0d: flags=%b cnt=%0d", i, flags, stack_count);
            check("fill_cnt", stack_count, i + 1);
        end
        step(0, 32'h0, 0, 1, 0, 0, 0, 0);
        $display("ninth push: cnt=%0d ovf=%b", stack_count, stack_overflow);
        check("full_cnt", stack_count, 8);
        check("full_ovf", stack_overflow, 1);
        for (int j = 0; j < 8; j++) begin
            step(0, 32'h0, 0, 0, 1, 0, 0, 0);
            $display("drain %0d: flags=%b cnt=%0d", j, flags, stack_count);
            check("lifo_flags", flags, hist[7-j]);
            check("lifo_cnt", stack_count, 7 - j);
        end

        // Three pushes, then reset asserted mid-cycle with a push in flight.
        for (int i = 0; i < 3; i++) step(1, 32'h0, 1, 1, 0, 0, 0, 0);
        check("pre_rst_cnt", stack_count, 3);
        push = 1'b1;
        do_reset();
        $display("after async reset: flags=%b cnt=%0d", flags, stack_count);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            int k;
            k = $urandom_range(0, 3);
            r = (k == 0) ? 32'h0 : (k == 1) ? 32'h8000_0000 : $urandom;
            step($urandom_range(0, 1) == 1, r, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0);
            $display("rand %0d: flags=%b cnt=%0d ovf=%b unf=%b",
                     n, flags, stack_count, stack_overflow, stack_underflow);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
